// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Covers index width, read-channel states, and the hazard/validity predicates.
package regfile_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned MAX_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t X0 = 5'd0;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    // x0 and anything beyond the implemented register count behave as a hard zero.
    function automatic logic idx_valid(input reg_idx_t idx, input int unsigned num_regs);
        return (idx != X0) && (32'(idx) < num_regs);
    endfunction

    // A source is held off while its producer is outstanding, unless that producer
    // is completing now; without forwarding, any write this cycle forces a retry.
    function automatic logic src_hazard(input logic [MAX_REGS-1:0] busy,
                                        input reg_idx_t            idx,
                                        input logic                wr_en,
                                        input reg_idx_t            wr_idx,
                                        input logic                bypass);
        logic busy_hit;
        logic cleared;
        busy_hit = busy[idx];
        cleared  = wr_en && (wr_idx == idx);
        return (busy_hit && !cleared) || (!bypass && wr_en);
    endfunction

endpackage

// File: rtl/regfile_sb_checker.sv
// Protocol checks for the register file read channel and scoreboard.
module regfile_sb_checker (
    input logic clk_i,
    input logic rst_ni,
    input logic stb_read_i,
    input logic read_pend_i,
    input logic busy0_i
);

    a_no_read_while_pending: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(stb_read_i && read_pend_i)
    );

    a_x0_never_busy: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !busy0_i
    );

endmodule

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: set by reserve, cleared by writeback.
// A reserve wins over a same-cycle clear of the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_en_i,
    input  reg_idx_t            clr_idx_i,
    input  logic                set_en_i,
    input  reg_idx_t            set_idx_i,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;

    // Next busy vector: clear first, then set, so the newer producer keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i && idx_valid(clr_idx_i, NUM_REGS)) begin
            busy_d[clr_idx_i[AW-1:0]] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (set_en_i && idx_valid(set_idx_i, NUM_REGS)) begin
            busy_d[set_idx_i[AW-1:0]] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with a destination scoreboard and an optional
// writeback-to-read forwarding path. Reads stall until their producers land.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stb_read_i,
    input  logic [4:0]          op_rs1_i,
    input  logic [4:0]          op_rs2_i,
    output logic                ack_read_o,
    output logic [XLEN-1:0]     reg_rs1_o,
    output logic [XLEN-1:0]     reg_rs2_o,
    input  logic                stb_write_i,
    input  logic [4:0]          op_rd_i,
    input  logic [XLEN-1:0]     reg_rd_i,
    output logic                ack_write_o,
    input  logic                stb_reserve_i,
    input  logic [4:0]          op_reserve_i,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam int unsigned AW     = $clog2(NUM_REGS);
    localparam logic        BYP_EN = (BYPASS != 0);

    logic [XLEN-1:0]     mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_s;
    logic [MAX_REGS-1:0] busy_ext_s;
    logic                wr_valid_s;

    rd_state_e           state_d, state_q;
    reg_idx_t            rs1_idx_d, rs1_idx_q;
    reg_idx_t            rs2_idx_d, rs2_idx_q;
    logic                ack_read_d, ack_read_q;
    logic                ack_write_d, ack_write_q;
    logic [XLEN-1:0]     rd1_d, rd1_q;
    logic [XLEN-1:0]     rd2_d, rd2_q;

    reg_idx_t            cur_rs1_s;
    reg_idx_t            cur_rs2_s;
    logic                hazard_s;
    logic [XLEN-1:0]     opnd1_s;
    logic [XLEN-1:0]     opnd2_s;

    assign wr_valid_s = stb_write_i && idx_valid(op_rd_i, NUM_REGS);

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_en_i  (stb_write_i),
        .clr_idx_i (op_rd_i),
        .set_en_i  (stb_reserve_i),
        .set_idx_i (op_reserve_i),
        .busy_o    (busy_s)
    );

    // Widen the busy vector so the hazard helper sees a fixed 32-entry view.
    always_comb begin
        busy_ext_s                 = '0;
        busy_ext_s[NUM_REGS-1:0]   = busy_s;
    end

    // Register array; deliberately not reset so contents survive a core reset.
    always_ff @(posedge clk_i) begin
        if (wr_valid_s) begin
            mem_q[op_rd_i[AW-1:0]] <= reg_rd_i;
        end
    end

    // Sources under evaluation: live indices on the strobe cycle, latched ones while waiting.
    always_comb begin
        if (state_q == RD_IDLE) begin
            cur_rs1_s = op_rs1_i;
            cur_rs2_s = op_rs2_i;
        end else begin
            cur_rs1_s = rs1_idx_q;
            cur_rs2_s = rs2_idx_q;
        end
        hazard_s = src_hazard(busy_ext_s, cur_rs1_s, stb_write_i, op_rd_i, BYP_EN)
                || src_hazard(busy_ext_s, cur_rs2_s, stb_write_i, op_rd_i, BYP_EN);
    end

    // Operand select: zero register, forwarded writeback data, or array contents.
    always_comb begin
        if (!idx_valid(cur_rs1_s, NUM_REGS)) begin
            opnd1_s = '0;
        end else if (BYP_EN && stb_write_i && (op_rd_i == cur_rs1_s)) begin
            opnd1_s = reg_rd_i;
        end else begin
            opnd1_s = mem_q[cur_rs1_s[AW-1:0]];
        end
        if (!idx_valid(cur_rs2_s, NUM_REGS)) begin
            opnd2_s = '0;
        end else if (BYP_EN && stb_write_i && (op_rd_i == cur_rs2_s)) begin
            opnd2_s = reg_rd_i;
        end else begin
            opnd2_s = mem_q[cur_rs2_s[AW-1:0]];
        end
    end

    // Read channel next-state and registered outputs.
    always_comb begin
        state_d     = state_q;
        rs1_idx_d   = rs1_idx_q;
        rs2_idx_d   = rs2_idx_q;
        ack_read_d  = 1'b0;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        ack_write_d = stb_write_i;
        case (state_q)
            RD_IDLE: begin
                if (stb_read_i) begin
                    rs1_idx_d = op_rs1_i;
                    rs2_idx_d = op_rs2_i;
                    if (hazard_s) begin
                        state_d = RD_WAIT;
                    end else begin
                        ack_read_d = 1'b1;
                        rd1_d      = opnd1_s;
                        rd2_d      = opnd2_s;
                    end
                end else begin
                    state_d = RD_IDLE;
                end
            end
            RD_WAIT: begin
                if (!hazard_s) begin
                    state_d    = RD_IDLE;
                    ack_read_d = 1'b1;
                    rd1_d      = opnd1_s;
                    rd2_d      = opnd2_s;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // Read channel state, latched indices and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RD_IDLE;
            rs1_idx_q   <= X0;
            rs2_idx_q   <= X0;
            ack_read_q  <= 1'b0;
            ack_write_q <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
        end else begin
            state_q     <= state_d;
            rs1_idx_q   <= rs1_idx_d;
            rs2_idx_q   <= rs2_idx_d;
            ack_read_q  <= ack_read_d;
            ack_write_q <= ack_write_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
        end
    end

    assign ack_read_o  = ack_read_q;
    assign ack_write_o = ack_write_q;
    assign reg_rs1_o   = rd1_q;
    assign reg_rs2_o   = rd2_q;
    assign busy_o      = busy_s;

    regfile_sb_checker u_checker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .stb_read_i  (stb_read_i),
        .read_pend_i (state_q == RD_WAIT),
        .busy0_i     (busy_s[0])
    );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the CPU register file. Configurable data width and register count (RV32I/RV32E).
- Adds an in-block scoreboard: the decode stage reserves a destination, and later reads stall until the producing write lands.
- Optional same-cycle write-to-read bypass.
- Sits between decode/issue (read and reserve ports) and writeback (write port) of the pipelined core.

Parameters:
XLEN, 32, register data width in bits
NUM_REGS, 32, architectural register count; legal values 16 (RV32E) or 32
BYPASS, 1, 1 = a write completing this cycle is forwarded to a pending read; 0 = write first, read retried next cycle

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
stb_read_i  in  1  read request strobe; indices captured on this cycle
op_rs1_i  in  5  first source index
op_rs2_i  in  5  second source index
ack_read_o  out  1  one-cycle pulse; reg_rs1_o/reg_rs2_o valid
reg_rs1_o  out  XLEN  first source value
reg_rs2_o  out  XLEN  second source value
stb_write_i  in  1  write strobe
op_rd_i  in  5  destination index
reg_rd_i  in  XLEN  write data
ack_write_o  out  1  one-cycle pulse, write done
stb_reserve_i  in  1  mark a destination busy
op_reserve_i  in  5  index to reserve
busy_o  out  NUM_REGS  scoreboard busy vector; bit 0 always 0

Behaviour:
Clock and reset:
- Single clock, clk_i.
- Reset rst_ni is asynchronous and active-low.
- While rst_ni = 0: ack_read_o = 0, ack_write_o = 0, reg_rs1_o = 0, reg_rs2_o = 0, busy_o = 0; pending read and latched indices cleared.
- Register array is not reset; contents persist across reset.
- Reset mid-read drops the read; no ack follows.

Index rules:
- x0 reads as 0 and is never busy.
- Writes to x0 are discarded but still acked.
- Any index >= NUM_REGS is treated like x0: read 0, write dropped, reserve ignored.

Write:
- Never stalls.
- stb_write_i sampled at edge N: array updated, busy[rd] cleared, ack_write_o = 1 for the cycle after edge N.
- Back-to-back writes are accepted every cycle.

Reserve:
- stb_reserve_i sets busy[op_reserve_i]; visible on busy_o next cycle.
- Reserve and write to the same index in the same cycle: busy stays set (new producer wins); data is still written.
- Reserving an already-busy register leaves it busy.

Read:
- stb_read_i latches rs1/rs2 into rs1_q/rs2_q and sets read_pend.
- Completion is evaluated in the strobe cycle and in every pending cycle after it.
- Read is blocked when either source (nonzero, in range) is busy and not being cleared by this cycle's write.
- With BYPASS=0, the read is also blocked whenever stb_write_i = 1.
- With BYPASS=1, a same-cycle write matching a source index supplies reg_rd_i for that operand.
- On completion: outputs registered, ack_read_o pulses 1 cycle, read_pend cleared.
- Minimum latency is 1 cycle (ack in the cycle after the strobe).
- A stall lasts until the producer write arrives; there is no timeout.
- stb_read_i while read_pend = 1 is a protocol error: ignored and flagged by an assertion.
- Outputs hold their last value between acks.

State machine (read channel):
- IDLE → WAIT on stb_read_i with a hazard.
- IDLE → IDLE (ack) on stb_read_i with no hazard.
- WAIT → IDLE (ack) when the hazard clears.

Decomposition:
Package regfile_pkg:
- REG_IDX_W = 5 and type reg_idx_t.
- X0 constant.
- Function idx_valid(idx, NUM_REGS).
- Function src_hazard(busy, idx, wr_en, wr_idx, BYPASS).

Sub-module regfile_scoreboard:
- Busy-bit vector with set/clear priority.
- Async reset, busy_o output.
- The array, read FSM and bypass mux stay in regfile_sb.

Test Plan:
- Write x5=0xDEADBEEF, then read rs1=5, rs2=0 → ack_write_o next cycle; ack_read_o 1 cycle after the read strobe with rs1=0xDEADBEEF, rs2=0.
- Reserve x7, read rs1=7 → no ack for 10 cycles, busy_o[7]=1; write x7=0x1234 → with BYPASS=1 ack in the cycle after the write carrying 0x1234; with BYPASS=0 the ack comes one cycle later.
- Same-cycle write x3=0xA5A5A5A5 and read rs1=3 with x3 not busy, BYPASS=0 → read acked one cycle after ack_write_o, value 0xA5A5A5A5.
- Same-cycle reserve and write of x9 → busy_o[9] stays 1; a subsequent read of x9 stalls until the second write.
- NUM_REGS=16: write x20=0xFFFF → acked, no change; read x20 → 0; reserve x20 → busy_o unchanged.
- Reserve x4, issue read of x4, then assert rst_ni=0 for 2 cycles mid-wait → no ack_read_o, busy_o=0 after reset; a new read of x4 acks in 1 cycle with the prior stored value.
